// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// State encoding, region split and requester id live here.
package mem_arbiter_rr_pkg;

  localparam int ADDR_W_DEF  = 7;
  localparam int DATA_W_DEF  = 8;
  localparam int ROM_TOP_DEF = 2;

  // Top address bits select the region; values below ROM_TOP are ROM
  localparam int REGION_W = 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  typedef logic req_id_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes
// to the requester that did not win last time.
module rr_pick2
  import mem_arbiter_rr_pkg::*;
(
  input  logic    req0,
  input  logic    req1,
  input  req_id_t last_grant,
  output logic    gnt_valid,
  output req_id_t gnt_id
);

  assign gnt_valid = req0 | req1;
  assign gnt_id    = req1 & ~(req0 & last_grant);

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter and access sequencer for one memory port.
// IDLE -> ACCESS -> RESP per transaction; ROM writes are blocked.
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_TOP = ROM_TOP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [REGION_W-1:0] LP_ROM_TOP = REGION_W'(ROM_TOP);

  logic [1:0]        r_state;
  req_id_t           r_last;
  req_id_t           r_id;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_err0;
  logic              r_err1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic    w_gnt_valid;
  req_id_t w_gnt_id;
  logic    w_rom_hit;
  logic    w_err;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (r_last),
    .gnt_valid  (w_gnt_valid),
    .gnt_id     (w_gnt_id)
  );

  assign w_rom_hit = r_addr[ADDR_W-1 -: REGION_W] < LP_ROM_TOP;
  assign w_err     = r_we & w_rom_hit;

  // rst_n gate keeps an aborted ACCESS from committing a write
  assign mem_we   = (r_state == S_ACCESS) & r_we & ~w_rom_hit & rst_n;
  assign mem_addr = r_addr;
  assign mem_din  = r_wdata;

  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign err0   = r_err0;
  assign err1   = r_err1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_valid) begin
            r_id    <= w_gnt_id;
            r_last  <= w_gnt_id;
            r_we    <= w_gnt_id ? we1 : we0;
            r_addr  <= w_gnt_id ? addr1 : addr0;
            r_wdata <= w_gnt_id ? wdata1 : wdata0;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_id) begin
            if (!r_we) r_rdata1 <= mem_dout;
            r_err1 <= w_err;
            r_err0 <= 1'b0;
            r_ack1 <= 1'b1;
          end else begin
            if (!r_we) r_rdata0 <= mem_dout;
            r_err0 <= w_err;
            r_err1 <= 1'b0;
            r_ack0 <= 1'b1;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr with a behavioural memory.
// Directed transactions push expectations; a monitor checks acks.
module tb_mem_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0;
  logic [6:0] addr0 = '0;
  logic [7:0] wdata0 = '0;
  logic       req1 = 1'b0, we1 = 1'b0;
  logic [6:0] addr1 = '0;
  logic [7:0] wdata1 = '0;
  logic       ack0, ack1, err0, err1;
  logic [7:0] rdata0, rdata1;
  logic       mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_din, mem_dout;

  always #5 clk = ~clk;

  mem_arbiter_rr dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // memory: fixed preload until a location is written
  logic [7:0]   ram [128];
  logic [127:0] wflag = '0;

  function automatic logic [7:0] init_val(input logic [6:0] a);
    case (a)
      7'd0:    return 8'd1;
      7'd7:    return 8'd21;
      7'd51:   return 8'd5;
      7'd105:  return 8'hEE;
      default: return {1'b0, a} ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [7:0] peek(input logic [6:0] a);
    return wflag[a] ? ram[a] : init_val(a);
  endfunction

  assign mem_dout = peek(mem_addr);

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]   <= mem_din;
      wflag[mem_addr] <= 1'b1;
    end
  end

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic       id;
    logic       rd;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (mem_we) we_cnt++;
    if (ack0 | ack1) begin
      chk("ack_excl", int'(ack0 & ack1), 0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", int'({ack1, ack0}), 0);
      end else begin
        e = sb.pop_front();
        chk("ack_id", int'(ack1), int'(e.id));
        if (ack1) begin
          chk("err1", int'(err1), int'(e.err));
          if (e.rd) chk("rdata1", int'(rdata1), int'(e.rdata));
        end else begin
          chk("err0", int'(err0), int'(e.err));
          if (e.rd) chk("rdata0", int'(rdata0), int'(e.rdata));
        end
      end
    end
  end

  task automatic push(input logic id, input logic rd,
                      input logic [7:0] d, input logic e);
    exp_t x;
    x.id = id; x.rd = rd; x.rdata = d; x.err = e;
    sb.push_back(x);
  endtask

  task automatic set_req(input logic id, input logic v, input logic w,
                         input logic [6:0] a, input logic [7:0] d);
    if (id) begin
      req1 = v; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = v; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  // counts negedges until the requester's ack; gives up after 20
  task automatic wait_ack(input logic id, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(id ? ack1 : ack0) && k < 20);
  endtask

  task automatic txn(input logic id, input logic w, input logic [6:0] a,
                     input logic [7:0] d, input logic [7:0] er,
                     input logic ee);
    int k;
    push(id, ~w, er, ee);
    @(negedge clk);
    set_req(id, 1'b1, w, a, d);
    wait_ack(id, k);
    chk(id ? "lat1" : "lat0", k, 2);
    set_req(id, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    int w0;
    do_reset();
    @(negedge clk);
    chk("rst_ack0", int'(ack0), 0);
    chk("rst_ack1", int'(ack1), 0);
    chk("rst_err", int'({err1, err0}), 0);
    chk("rst_rdata", int'({rdata1, rdata0}), 0);
    chk("rst_maddr", int'(mem_addr), 0);
    chk("rst_mdin", int'(mem_din), 0);
    chk("rst_mwe", int'(mem_we), 0);

    // 1: SRAM write then read back
    w0 = we_cnt;
    txn(1'b0, 1'b1, 7'b10_00_000, 8'd10, 8'd0, 1'b0);
    chk("t1_we_cycles", we_cnt - w0, 1);
    chk("t1_mem", int'(peek(7'b10_00_000)), 10);
    txn(1'b0, 1'b0, 7'b10_00_000, 8'd0, 8'd10, 1'b0);

    // 2: requester 1 ROM reads
    txn(1'b1, 1'b0, 7'b00_00_111, 8'd0, 8'd21, 1'b0);
    txn(1'b1, 1'b0, 7'b01_10_011, 8'd0, 8'd5, 1'b0);

    // 3: ROM write rejected
    w0 = we_cnt;
    txn(1'b0, 1'b1, 7'b00_00_000, 8'd5, 8'd0, 1'b1);
    chk("t3_we_cycles", we_cnt - w0, 0);
    chk("t3_mem", int'(peek(7'b00_00_000)), 1);
    txn(1'b0, 1'b0, 7'b00_00_000, 8'd0, 8'd1, 1'b0);

    // 4: both held from reset, alternating grants
    do_reset();
    for (int i = 0; i < 4; i++) push(i[0], 1'b1, i[0] ? 8'd5 : 8'd21, 1'b0);
    set_req(1'b0, 1'b1, 1'b0, 7'd7, 8'd0);
    set_req(1'b1, 1'b1, 1'b0, 7'd51, 8'd0);
    for (int i = 0; i < 4; i++) begin
      wait_ack(i[0], k);
      chk(i == 0 ? "t4_first" : "t4_space", k, i == 0 ? 2 : 3);
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);

    // 5: reset during ACCESS aborts the write, retry succeeds
    @(negedge clk);
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b1, 7'b11_01_001, 8'd15);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_noack", int'(ack1), 0);
    chk("t5_mem_kept", int'(peek(7'b11_01_001)), 8'hEE);
    rst_n = 1'b1;
    push(1'b1, 1'b0, 8'd0, 1'b0);
    wait_ack(1'b1, k);
    chk("t5_retry_lat", k, 2);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    chk("t5_mem", int'(peek(7'b11_01_001)), 15);
    txn(1'b1, 1'b0, 7'b11_01_001, 8'd0, 8'd15, 1'b0);

    // 6: req0 back-to-back, then tie goes to req1
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 8'd21, 1'b0);
    set_req(1'b0, 1'b1, 1'b0, 7'd7, 8'd0);
    for (int i = 0; i < 4; i++) begin
      wait_ack(1'b0, k);
      chk(i == 0 ? "t6_first" : "t6_space", k, i == 0 ? 2 : 3);
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    push(1'b1, 1'b1, 8'd5, 1'b0);
    push(1'b0, 1'b1, 8'd21, 1'b0);
    set_req(1'b0, 1'b1, 1'b0, 7'd7, 8'd0);
    set_req(1'b1, 1'b1, 1'b0, 7'd51, 8'd0);
    wait_ack(1'b1, k);
    chk("t6_tie_req1", k, 2);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    wait_ack(1'b0, k);
    chk("t6_then_req0", k, 3);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);

    repeat (6) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
